conv: RTL and testbench
=======================

# conv

Sequential 3×3 convolution engine for one feature-map channel. It reads a fixed 16×15 unsigned 8-bit image and a signed 3×3 kernel through array ports. It produces the 14×13 "valid" output map one pixel at a time, in row-major order, with optional ReLU and 8-bit truncation. Each result is offered to the downstream storage logic on a valid/save_done handshake; it sits between the layer buffers and the result writer of the NPU datapath.

## Interface
Parameters:
- K_H, 3, kernel rows
- K_W, 3, kernel columns
- MAX_H, 16, input image rows
- MAX_W, 15, input image columns
- DATA_WIDTH, 8, pixel/weight width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-high despite the name (1 = reset)
- trigger  in  1  start request; rising edge starts a full pass
- save_done  in  1  one-cycle pulse: consumer has stored the current pixel
- layer  in  1  0 = conv1 (ReLU on), 1 = conv2 (ReLU off)
- in_img  in  unpacked [0:MAX_H*MAX_W-1] of DATA_WIDTH  unsigned pixels, index = row*MAX_W + col
- w_conv  in  unpacked [K_H][K_W] of signed DATA_WIDTH  kernel, w_conv[r][c]
- valid  out  1  out_pixel/addr hold a result
- out_pixel  out  8  result pixel, unsigned
- addr  out  8  output index = orow*13 + ocol, 0..181

## Operation
- Output map is OUT_H = MAX_H-K_H+1 = 14 rows by OUT_W = MAX_W-K_W+1 = 13 columns, giving 182 pixels. The geometry is the same for both layer values.
- Arithmetic per output (orow, ocol): acc = Σ_{r,c} $signed({1'b0, in_img[(orow+r)*15 + ocol+c]}) * w_conv[r][c].
  - Each product is 9b×8b signed. The accumulator is at least 21 bits signed, so there is no overflow.
- Post-processing:
  - layer==0 and acc<0: out_pixel = 0.
  - All other cases: out_pixel = acc[7:0], a plain low-byte truncation with no saturation, including layer 0 positive overflow.
- Start detection: a registered copy trigger_d. A start is trigger & ~trigger_d, sampled in IDLE only. Holding trigger high gives one start.
- FSM:
  - IDLE: valid=0. On a start, set the index to 0 and go to CALC.
  - CALC, one cycle: compute the MAC combinationally for the current index. Register out_pixel and addr, set valid=1, go to WAIT.
  - WAIT: hold valid, out_pixel and addr stable. When save_done=1, clear valid. If addr==181, go to IDLE. Otherwise advance the index (ocol+1, wrapping to the next orow after ocol 12) and go to CALC.
- Ignored inputs:
  - trigger edges while not in IDLE.
  - save_done outside WAIT.
  - in_img and w_conv must stay stable from start until the last pixel is consumed.

## Timing
- Reset values: valid=0, out_pixel=0, addr=0, state IDLE, index 0, trigger_d=0. Reset mid-pass aborts immediately with no output.
- Latency:
  - Start edge sampled at edge T: CALC during cycle T→T+1, valid=1 after edge T+1.
  - save_done sampled at edge S: valid=0 after edge S (same edge), next valid=1 after edge S+1.
  - So valid is low for exactly one cycle between consecutive pixels.
- No result is skipped or repeated. The pass completes after 182 handshakes, and a later trigger edge starts a new pass.

## Test plan
- Ramp test:
  - Stimulus: in_img[i]=i (i<240), w[r][c]=(r-1)+(c-1), layer=0, trigger pulse, save_done 3 cycles after each valid.
  - Required: 182 valids, addr 0..181 in order, every out_pixel=96, return to IDLE.
- Negated ramp weights:
  - layer=0: every out_pixel=0.
  - layer=1: every out_pixel=160 (low byte of −96).
- Overflow:
  - All pixels 255, all weights 127, layer=0: out_pixel=137 (291465 mod 256).
  - All weights −128, layer=1: out_pixel=128; the same with layer=0: out_pixel=0.
- Handshake stall:
  - Stimulus: withhold save_done for 50 cycles.
  - Required: valid stays 1 with addr=0 and out_pixel stable.
  - Required: trigger pulses during the pass have no effect, and save_done pulses in IDLE have no effect.
  - Required: after save_done, valid=0 for one cycle, then addr=1.
- Reset:
  - Stimulus: assert rst_n=1 for one cycle while addr=40 is pending.
  - Required: valid=0 and addr=0 next cycle, no further outputs until a new trigger edge, and the new pass restarts at addr 0.

Source files
------------

// File: rtl/conv.sv
// conv: sequential 3x3 "valid" convolution over one 16x15 unsigned 8-bit
// channel, producing a 14x13 map one pixel at a time in row-major order.
// Each result is held on out_pixel/addr with valid high until the consumer
// pulses save_done.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-high (1 = reset) despite the name
//   trigger    start request; a rising edge seen in IDLE starts a full pass
//   save_done  one-cycle pulse: consumer has stored the current pixel
//   layer      0 = ReLU applied, 1 = no ReLU
//   in_img     unsigned pixels, index = row*MAX_W + col
//   w_conv     signed kernel, w_conv[r][c]
//   valid      out_pixel/addr hold a result
//   out_pixel  result pixel (low byte of the accumulator, or 0 after ReLU)
//   addr       output index = orow*OUT_W + ocol
module conv #(
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int MAX_H      = 16,
  parameter int MAX_W      = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trigger,
  input  logic                         save_done,
  input  logic                         layer,
  input  logic [DATA_WIDTH-1:0]        in_img [0:MAX_H*MAX_W-1],
  input  logic signed [DATA_WIDTH-1:0] w_conv [K_H][K_W],
  output logic                         valid,
  output logic [7:0]                   out_pixel,
  output logic [7:0]                   addr
);

  localparam int OUT_H  = MAX_H - K_H + 1;
  localparam int OUT_W  = MAX_W - K_W + 1;
  localparam int NPIX   = OUT_H * OUT_W;
  localparam int IDX_W  = $clog2(MAX_H * MAX_W);
  localparam int OROW_W = $clog2(OUT_H);
  localparam int OCOL_W = $clog2(OUT_W);
  // 9b x 8b products summed over the kernel; generous headroom.
  localparam int ACC_W  = 2 * DATA_WIDTH + 5;

  typedef enum logic [1:0] {IDLE, CALC, WAIT} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [7:0]          pix_q, pix_d;
  logic [7:0]          addr_q, addr_d;
  logic [OROW_W-1:0]   orow_q, orow_d;
  logic [OCOL_W-1:0]   ocol_q, ocol_d;
  logic                trig_q;

  logic [IDX_W-1:0]        pix_idx;
  logic signed [ACC_W-1:0] px, wt, acc;
  logic [7:0]              cur_addr;

  // ReLU (layer 0 only) followed by plain low-byte truncation, no saturation.
  function automatic logic [7:0] post_proc(input logic signed [ACC_W-1:0] a,
                                           input logic lyr);
    if (!lyr && a[ACC_W-1]) return 8'd0;
    return a[7:0];
  endfunction

  always_comb begin : mac_comb
    acc     = '0;
    pix_idx = '0;
    px      = '0;
    wt      = '0;
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W; c++) begin
        pix_idx = IDX_W'((int'(orow_q) + r) * MAX_W + int'(ocol_q) + c);
        // Pixels are unsigned: zero-extend so they stay non-negative.
        px  = $signed({{(ACC_W-DATA_WIDTH){1'b0}}, in_img[pix_idx]});
        wt  = {{(ACC_W-DATA_WIDTH){w_conv[r][c][DATA_WIDTH-1]}}, w_conv[r][c]};
        acc = acc + px * wt;
      end
    end
  end

  assign cur_addr = 8'(int'(orow_q) * OUT_W + int'(ocol_q));

  always_comb begin : fsm_comb
    state_d = state_q;
    valid_d = valid_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (trigger && !trig_q) begin
          orow_d  = '0;
          ocol_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        pix_d   = post_proc(acc, layer);
        addr_d  = cur_addr;
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (save_done) begin
          valid_d = 1'b0;
          if (addr_q == 8'(NPIX - 1)) begin
            state_d = IDLE;
          end else begin
            if (ocol_q == OCOL_W'(OUT_W - 1)) begin
              ocol_d = '0;
              orow_d = orow_q + 1'b1;
            end else begin
              ocol_d = ocol_q + 1'b1;
            end
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      pix_q   <= '0;
      addr_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      trig_q  <= trigger;
    end
  end

  assign valid     = valid_q;
  assign out_pixel = pix_q;
  assign addr      = addr_q;

endmodule

// File: tb/tb_conv.sv
module tb_conv;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              trigger;
  logic              save_done;
  logic              layer;
  logic [7:0]        img [0:239];
  logic signed [7:0] w [3][3];
  logic              valid;
  logic [7:0]        out_pixel;
  logic [7:0]        addr;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  conv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trigger  (trigger),
    .save_done(save_done),
    .layer    (layer),
    .in_img   (img),
    .w_conv   (w),
    .valid    (valid),
    .out_pixel(out_pixel),
    .addr     (addr)
  );

  function automatic logic [7:0] model(input int orow, input int ocol, input logic lyr);
    int a;
    a = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        a += int'(img[(orow + r) * 15 + ocol + c]) * int'(w[r][c]);
    if (!lyr && a < 0) return 8'd0;
    return a[7:0];
  endfunction

  // expv >= 0: every pixel of the pass is that constant; else use the model.
  task automatic push_pass(input int expv);
    logic [7:0] p;
    for (int orow = 0; orow < 14; orow++)
      for (int ocol = 0; ocol < 13; ocol++) begin
        p = (expv >= 0) ? 8'(expv) : model(orow, ocol, layer);
        sb.push_back({8'(orow * 13 + ocol), p});
      end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic set_ramp_w(input int sgn);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = 8'(sgn * ((r - 1) + (c - 1)));
  endtask

  task automatic set_ramp_img();
    for (int i = 0; i < 240; i++) img[i] = 8'(i);
  endtask

  task automatic consume(input int n, input int dly);
    logic [15:0] e;
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (valid !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL valid_timeout k=%0d valid=%b required 1", k, valid);
        return;
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_output addr=%0d pix=%0d required none", addr, out_pixel);
        return;
      end
      e = sb.pop_front();
      if ({addr, out_pixel} !== e) begin
        errors++;
        $display("FAIL pixel addr=%0d pix=%0d required addr=%0d pix=%0d",
                 addr, out_pixel, e[15:8], e[7:0]);
      end
      repeat (dly) @(negedge clk);
      save_done = 1'b1;
      @(negedge clk);
      save_done = 1'b0;
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_low valid=%b required 0", valid);
      end
      if (e[15:8] != 8'd181) begin
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
          errors++;
          $display("FAIL gap_one_cycle valid=%b required 1", valid);
        end
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s valid seen high, required idle", name);
    end
  endtask

  task automatic run_pass(input logic lyr, input int expv, input string name);
    layer = lyr;
    sb.delete();
    push_pass(expv);
    pulse_trigger();
    consume(182, 3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_left %0d pending, required 0", name, sb.size());
    end
    check_idle({name, "_idle"}, 10);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    trigger = 1'b0;
    save_done = 1'b0;
    layer = 1'b0;
    set_ramp_img();
    set_ramp_w(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if ({valid, addr, out_pixel} !== 17'd0) begin
      errors++;
      $display("FAIL reset_vals valid=%b addr=%0d pix=%0d required 0/0/0", valid, addr, out_pixel);
    end
    save_done = 1'b1;
    @(negedge clk);
    save_done = 1'b0;
    check_idle("reset_idle", 10);
  endtask

  task automatic test_ramp();
    set_ramp_img();
    set_ramp_w(1);
    run_pass(1'b0, 96, "ramp");
  endtask

  task automatic test_neg_ramp();
    set_ramp_img();
    set_ramp_w(-1);
    run_pass(1'b0, 0, "negramp_l0");
    run_pass(1'b1, 160, "negramp_l1");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 240; i++) img[i] = 8'd255;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) w[r][c] = 8'sd127;
    run_pass(1'b0, 137, "ovf_pos");
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) w[r][c] = -8'sd128;
    run_pass(1'b1, 128, "ovf_neg_l1");
    run_pass(1'b0, 0, "ovf_neg_l0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 240; i++) img[i] = 8'($urandom);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) w[r][c] = 8'($urandom);
    run_pass(1'b0, -1, "rand_l0");
    // Trigger held high through a whole pass must yield only one start.
    layer = 1'b1;
    sb.delete();
    push_pass(-1);
    trigger = 1'b1;
    consume(182, 1);
    check_idle("held_trigger", 10);
    trigger = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [15:0] e;
    logic stable;
    int t;
    set_ramp_img();
    set_ramp_w(1);
    layer = 1'b0;
    sb.delete();
    push_pass(96);
    pulse_trigger();
    t = 0;
    while (valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    e = sb.pop_front();
    checks++;
    if ({valid, addr, out_pixel} !== {1'b1, e}) begin
      errors++;
      $display("FAIL stall_first valid=%b addr=%0d pix=%0d required 1/%0d/%0d",
               valid, addr, out_pixel, e[15:8], e[7:0]);
    end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      trigger = (i % 10) < 2;
      @(negedge clk);
      if ({valid, addr, out_pixel} !== {1'b1, e}) stable = 1'b0;
    end
    trigger = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL stall_hold valid=%b addr=%0d pix=%0d required stable 1/%0d/%0d",
               valid, addr, out_pixel, e[15:8], e[7:0]);
    end
    save_done = 1'b1;
    @(negedge clk);
    save_done = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release valid=%b required 0", valid);
    end
    @(negedge clk);
    checks++;
    if ({valid, addr} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL stall_next valid=%b addr=%0d required 1/1", valid, addr);
    end
    consume(181, 2);
    for (int i = 0; i < 5; i++) begin
      save_done = 1'b1;
      @(negedge clk);
      save_done = 1'b0;
      @(negedge clk);
    end
    check_idle("stall_idle_savedone", 10);
  endtask

  task automatic test_reset_mid();
    set_ramp_img();
    set_ramp_w(1);
    layer = 1'b0;
    sb.delete();
    push_pass(96);
    pulse_trigger();
    consume(40, 1);
    checks++;
    if ({valid, addr} !== {1'b1, 8'd40}) begin
      errors++;
      $display("FAIL mid_pending valid=%b addr=%0d required 1/40", valid, addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if ({valid, addr} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%b addr=%0d required 0/0", valid, addr);
    end
    check_idle("mid_reset_idle", 20);
    run_pass(1'b0, 96, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_neg_ramp();
    test_overflow();
    test_random();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
